clk_div_multi: RTL

//  Multi-channel programmable clock divider/enable generator for the VGA

---
 rtl/clk_div_multi_if.sv | 27 ++
 rtl/clk_div_multi.sv | 92 +++++++++
 2 files changed

// File: rtl/clk_div_multi_if.sv
// Control/status bundle for the multi-channel clock divider.
// master drives the controls and observes the divided outputs; slave is the divider itself.
interface clk_div_multi_if #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned W      = 8
);
  localparam int unsigned CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              en;
  logic              sync_clr;
  logic              load;
  logic [CHW-1:0]    load_ch;
  logic [W-1:0]      load_div;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] pend;

  modport master (
    output en, sync_clr, load, load_ch, load_div,
    input  clk_out, tick, pend
  );

  modport slave (
    input  en, sync_clr, load, load_ch, load_div,
    output clk_out, tick, pend
  );
endinterface

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: per channel a divided square wave and a
// one-cycle tick per period. Reloaded ratios wait for a period boundary before taking effect.
module clk_div_multi #(
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned W       = 8,
  parameter int unsigned DEF_DIV = 8
) (
  input  logic           clk_in,
  input  logic           reset,
  clk_div_multi_if.slave bus
);
  localparam int unsigned CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [W-1:0]      cnt_q      [NUM_CH];
  logic [W-1:0]      div_act_q  [NUM_CH];
  logic [W-1:0]      div_pend_q [NUM_CH];
  logic [NUM_CH-1:0] pend_q;
  logic [NUM_CH-1:0] clk_out_q;
  logic [NUM_CH-1:0] tick_q;

  logic [W-1:0]      last_cnt   [NUM_CH];
  logic [W-1:0]      fall_cnt   [NUM_CH];
  logic [NUM_CH-1:0] load_hit;
  logic [W-1:0]      load_val;

  always_comb begin
    load_val = (bus.load_div < W'(2)) ? W'(2) : bus.load_div;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      last_cnt[i] = div_act_q[i] - W'(1);
      // Falling edge after the high half: H = floor(N/2), so odd N spends the extra cycle low.
      fall_cnt[i] = (div_act_q[i] >> 1) - W'(1);
      // Out-of-range channel numbers match no channel and are dropped here.
      load_hit[i] = bus.load && (32'(bus.load_ch) == 32'(i));
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        cnt_q[i]      <= '0;
        div_act_q[i]  <= W'(DEF_DIV);
        div_pend_q[i] <= W'(DEF_DIV);
      end
      pend_q    <= '0;
      clk_out_q <= '0;
      tick_q    <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        if (bus.sync_clr) begin
          cnt_q[i]     <= '0;
          clk_out_q[i] <= 1'b0;
          tick_q[i]    <= 1'b0;
          pend_q[i]    <= 1'b0;
          // A load on the clearing edge is newer than any pending ratio.
          if (load_hit[i]) begin
            div_act_q[i] <= load_val;
          end else if (pend_q[i]) begin
            div_act_q[i] <= div_pend_q[i];
          end
        end else begin
          tick_q[i] <= 1'b0;
          if (bus.en) begin
            if (cnt_q[i] == last_cnt[i]) begin
              cnt_q[i]     <= '0;
              tick_q[i]    <= 1'b1;
              clk_out_q[i] <= 1'b1;
              if (pend_q[i]) begin
                div_act_q[i] <= div_pend_q[i];
                pend_q[i]    <= 1'b0;
              end
            end else begin
              cnt_q[i] <= cnt_q[i] + W'(1);
              if (cnt_q[i] == fall_cnt[i]) begin
                clk_out_q[i] <= 1'b0;
              end
            end
          end
          // Placed last so a load coinciding with a wrap stays pending for the next wrap.
          if (load_hit[i]) begin
            div_pend_q[i] <= load_val;
            pend_q[i]     <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.clk_out = clk_out_q;
  assign bus.tick    = tick_q;
  assign bus.pend    = pend_q;

endmodule
